// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
// Shared types for the RV32I decode stage: instruction class and ALU
// operation enums, funct3 enums, opcode constants, the decoded_t record
// stored in the output queue, and the PC_JMP_* / WR_SRC_* encodings.
// The RV32M ALU members are always declared; whether the decoder produces
// them depends on the DECODE_RV32M_EN macro (see decode_logic).
package decode_stage_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_UA = 7'b0010111;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] PC_JMP_NONE = 3'd0;
    localparam logic [2:0] PC_JMP_JAL  = 3'd1;
    localparam logic [2:0] PC_JMP_BT   = 3'd2;  // branch if ALU compare true
    localparam logic [2:0] PC_JMP_BF   = 3'd3;  // branch if ALU compare false
    localparam logic [2:0] PC_JMP_JALR = 3'd4;

    localparam logic [1:0] WR_SRC_ALU = 2'd0;
    localparam logic [1:0] WR_SRC_MEM = 2'd1;
    localparam logic [1:0] WR_SRC_PC4 = 2'd2;
    localparam logic [1:0] WR_SRC_IMM = 2'd3;

    // INST_R must stay 0: an empty queue and an illegal word both read as R.
    typedef enum logic [3:0] {
        INST_R, INST_I, INST_L, INST_S, INST_B, INST_J, INST_JR, INST_U, INST_UA
    } inst_type_t;

    // ALU_ADD must stay 0 so an all-zero record decodes as a harmless ADD.
    // The eight M ops are contiguous in funct3 order.
    typedef enum logic [5:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI,
        ALU_ANDI, ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_EQL, ALU_LT, ALU_GE,
        ALU_LTU, ALU_GEU, ALU_ADDPC, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } ALU_func_t;

    typedef enum logic [2:0] {
        F3R_ADD, F3R_SLL, F3R_SLT, F3R_SLTU, F3R_XOR, F3R_SRL, F3R_OR, F3R_AND
    } r_funct3_t;

    typedef enum logic [2:0] {
        F3I_ADDI, F3I_SLLI, F3I_SLTI, F3I_SLTIU, F3I_XORI, F3I_SRLI, F3I_ORI, F3I_ANDI
    } i_funct3_t;

    typedef enum logic [2:0] {
        F3B_BEQ = 3'd0, F3B_BNE = 3'd1, F3B_BLT = 3'd4,
        F3B_BGE = 3'd5, F3B_BLTU = 3'd6, F3B_BGEU = 3'd7
    } b_funct3_t;

    typedef enum logic [2:0] {
        F3L_LB = 3'd0, F3L_LH = 3'd1, F3L_LW = 3'd2, F3L_LBU = 3'd4, F3L_LHU = 3'd5
    } l_funct3_t;

    typedef enum logic [2:0] {
        F3S_SB = 3'd0, F3S_SH = 3'd1, F3S_SW = 3'd2
    } s_funct3_t;

    // Immediates are at most 32 significant bits; the stage sign-extends to XLEN.
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        inst_type_t  inst_type;
        logic        rd_en1;
        logic        rd_en2;
        logic [2:0]  wr_en;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_size;
        ALU_func_t   alu_func;
        logic [2:0]  pc_jmp;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic ALU_func_t m_func(input logic [2:0] funct3);
        return ALU_func_t'(6'(ALU_MUL) + {3'b000, funct3});
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
// Fetch-side and execute-side handshake bundle of the decode stage.
//   master: environment (drives in_*, flush, out_ready; observes the rest)
//   slave : decode_stage
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// the producer holds payload while valid && !ready. flush overrides both
// sides for that cycle.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    import decode_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     instruction;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    inst_type_t      inst_type;
    logic            rd_en1;
    logic            rd_en2;
    logic [2:0]      wr_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      mem_size;
    ALU_func_t       ALU_func;
    logic [2:0]      pc_jmp;
    logic            illegal;

    modport master (
        output in_valid, in_pc, instruction, flush, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, inst_type,
               rd_en1, rd_en2, wr_en, mem_rd, mem_wr, mem_size, ALU_func,
               pc_jmp, illegal
    );

    modport slave (
        input  in_valid, in_pc, instruction, flush, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, inst_type,
               rd_en1, rd_en2, wr_en, mem_rd, mem_wr, mem_size, ALU_func,
               pc_jmp, illegal
    );
endinterface

// File: rtl/decode_stage_decode_logic.sv
// decode_logic
// Purely combinational RV32I decoder.
//   instr_i : raw 32-bit instruction
//   dec_o   : decoded_t record (register fields, immediate, enables, ALU op)
// Macro DECODE_RV32M_EN: when defined, R-type funct7=0000001 decodes to the
// RV32M ops; otherwise those encodings are flagged illegal.
module decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alt;   // instr[30]: selects SUB / SRA / SRAI

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign alt    = instr_i[30];

    always_comb begin
        dec_o     = '0;
        dec_o.rd  = instr_i[11:7];
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        case (opcode)
            OP_R: begin
                dec_o.inst_type = INST_R;
                dec_o.rd_en1    = 1'b1;
                dec_o.rd_en2    = 1'b1;
                dec_o.wr_en     = {WR_SRC_ALU, 1'b1};
                if (funct7 == FUNCT7_M) begin
`ifdef DECODE_RV32M_EN
                    dec_o.alu_func = m_func(funct3);
`else
                    dec_o.illegal  = 1'b1;
`endif
                end else begin
                    case (funct3)
                        F3R_ADD:  dec_o.alu_func = alt ? ALU_SUB : ALU_ADD;
                        F3R_SLL:  dec_o.alu_func = ALU_SLL;
                        F3R_SLT:  dec_o.alu_func = ALU_SLT;
                        F3R_SLTU: dec_o.alu_func = ALU_SLTU;
                        F3R_XOR:  dec_o.alu_func = ALU_XOR;
                        F3R_SRL:  dec_o.alu_func = alt ? ALU_SRA : ALU_SRL;
                        F3R_OR:   dec_o.alu_func = ALU_OR;
                        default:  dec_o.alu_func = ALU_AND;
                    endcase
                end
            end
            OP_I: begin
                dec_o.inst_type = INST_I;
                dec_o.imm       = sext12(instr_i[31:20]);
                dec_o.rd_en1    = 1'b1;
                dec_o.wr_en     = {WR_SRC_ALU, 1'b1};
                case (funct3)
                    F3I_ADDI:  dec_o.alu_func = ALU_ADDI;
                    F3I_SLLI:  dec_o.alu_func = ALU_SLLI;
                    F3I_SLTI:  dec_o.alu_func = ALU_SLTI;
                    F3I_SLTIU: dec_o.alu_func = ALU_SLTIU;
                    F3I_XORI:  dec_o.alu_func = ALU_XORI;
                    F3I_SRLI:  dec_o.alu_func = alt ? ALU_SRAI : ALU_SRLI;
                    F3I_ORI:   dec_o.alu_func = ALU_ORI;
                    default:   dec_o.alu_func = ALU_ANDI;
                endcase
            end
            OP_L: begin
                dec_o.inst_type = INST_L;
                dec_o.imm       = sext12(instr_i[31:20]);
                dec_o.rd_en1    = 1'b1;
                dec_o.wr_en     = {WR_SRC_MEM, 1'b1};
                dec_o.mem_rd    = 1'b1;
                dec_o.mem_size  = funct3;
                dec_o.alu_func  = ALU_ADD;
            end
            OP_S: begin
                dec_o.inst_type = INST_S;
                dec_o.imm       = sext12({instr_i[31:25], instr_i[11:7]});
                dec_o.rd_en1    = 1'b1;
                dec_o.rd_en2    = 1'b1;
                dec_o.mem_wr    = 1'b1;
                dec_o.mem_size  = funct3;
                dec_o.alu_func  = ALU_ADD;
            end
            OP_B: begin
                dec_o.inst_type = INST_B;
                dec_o.imm       = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                   instr_i[30:25], instr_i[11:8], 1'b0};
                dec_o.rd_en1    = 1'b1;
                dec_o.rd_en2    = 1'b1;
                dec_o.pc_jmp    = PC_JMP_BT;
                case (funct3)
                    F3B_BEQ:  dec_o.alu_func = ALU_EQL;
                    F3B_BNE: begin
                        dec_o.alu_func = ALU_EQL;
                        dec_o.pc_jmp   = PC_JMP_BF;
                    end
                    F3B_BLT:  dec_o.alu_func = ALU_LT;
                    F3B_BGE:  dec_o.alu_func = ALU_GE;
                    F3B_BLTU: dec_o.alu_func = ALU_LTU;
                    F3B_BGEU: dec_o.alu_func = ALU_GEU;
                    default:  dec_o.illegal  = 1'b1;  // funct3 010/011 unassigned
                endcase
            end
            OP_J: begin
                dec_o.inst_type = INST_J;
                dec_o.imm       = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                   instr_i[20], instr_i[30:21], 1'b0};
                dec_o.wr_en     = {WR_SRC_PC4, 1'b1};
                dec_o.pc_jmp    = PC_JMP_JAL;
            end
            OP_JR: begin
                dec_o.inst_type = INST_JR;
                dec_o.imm       = sext12(instr_i[31:20]);
                dec_o.rd_en1    = 1'b1;
                dec_o.wr_en     = {WR_SRC_PC4, 1'b1};
                dec_o.pc_jmp    = PC_JMP_JALR;
                dec_o.alu_func  = ALU_ADD;
            end
            OP_U: begin
                dec_o.inst_type = INST_U;
                dec_o.imm       = {instr_i[31:12], 12'b0};
                dec_o.wr_en     = {WR_SRC_IMM, 1'b1};
            end
            OP_UA: begin
                dec_o.inst_type = INST_UA;
                dec_o.imm       = {instr_i[31:12], 12'b0};
                dec_o.wr_en     = {WR_SRC_ALU, 1'b1};
                dec_o.alu_func  = ALU_ADDPC;
            end
            default: dec_o.illegal = 1'b1;
        endcase

        // An illegal word carries nothing but the flag.
        if (dec_o.illegal) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// RV32I decode stage: decodes {pc, instruction} words and buffers the
// results in a DEPTH-entry circular queue between fetch and execute.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_stage_if.slave (in_* / flush from fetch, out_* to
//                execute, decoded payload of the head entry)
// Parameters XLEN (data/PC width, >= 32) and DEPTH (power of two, >= 2).
// Macro DECODE_RV32M_EN enables RV32M decode inside decode_logic.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    decoded_t         dec_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q  [DEPTH];

    decoded_t         dec_w;
    decoded_t         head;
    logic [XLEN-1:0]  head_pc;
    logic             push;
    logic             pop;

    decode_logic u_decode (
        .instr_i (bus.instruction),
        .dec_o   (dec_w)
    );

    // in_ready looks only at the registered count, so a pop in the same
    // cycle does not open the input: no out_ready -> in_ready path.
    assign bus.in_ready  = (count_q < DEPTH_C);
    assign bus.out_valid = (count_q != '0);
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem_q[wr_ptr_q] <= dec_w;
            pc_mem_q[wr_ptr_q]  <= bus.in_pc;
        end
    end

    always_comb begin
        head    = '0;
        head_pc = '0;
        if (bus.out_valid) begin
            head    = dec_mem_q[rd_ptr_q];
            head_pc = pc_mem_q[rd_ptr_q];
        end
    end

    assign bus.out_pc    = head_pc;
    assign bus.rd        = head.rd;
    assign bus.rs1       = head.rs1;
    assign bus.rs2       = head.rs2;
    assign bus.imm       = XLEN'($signed(head.imm));
    assign bus.inst_type = head.inst_type;
    assign bus.rd_en1    = head.rd_en1;
    assign bus.rd_en2    = head.rd_en2;
    assign bus.wr_en     = head.wr_en;
    assign bus.mem_rd    = head.mem_rd;
    assign bus.mem_wr    = head.mem_wr;
    assign bus.mem_size  = head.mem_size;
    assign bus.ALU_func  = head.alu_func;
    assign bus.pc_jmp    = head.pc_jmp;
    assign bus.illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Directed and randomized bench for decode_stage (XLEN=32, DEPTH=2).
// The expected queue holds records produced by a reference decoder written
// from the instruction-set rules; every cycle the head of the DUT is
// compared with the head of that queue. Honours DECODE_RV32M_EN.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        inst_type_t  it;
        logic        re1;
        logic        re2;
        logic [2:0]  wr;
        logic        mrd;
        logic        mwr;
        logic [2:0]  msize;
        ALU_func_t   alu;
        logic [2:0]  pj;
        logic        ill;
    } exp_t;
    localparam int W = $bits(exp_t);

    localparam ALU_func_t R_TBL [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                        ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam ALU_func_t I_TBL [8] = '{ALU_ADDI, ALU_SLLI, ALU_SLTI, ALU_SLTIU,
                                        ALU_XORI, ALU_SRLI, ALU_ORI, ALU_ANDI};
    localparam ALU_func_t M_TBL [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    localparam ALU_func_t B_ALU [8] = '{ALU_EQL, ALU_EQL, ALU_ADD, ALU_ADD,
                                        ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    localparam logic [2:0] B_JMP [8] = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) bus ();

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic [2:0] f3;
        int s;
        f3 = ins[14:12];
        s  = $signed(ins);
        e = '0;
        e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        case (ins[6:0])
            7'b0110011: begin
                e.it = INST_R; e.re1 = 1; e.re2 = 1; e.wr = 3'b001;
                if (ins[31:25] == 7'b0000001) begin
                    e.alu = M_TBL[f3];
                    e.ill = !M_EN;
                end else if (ins[30] && f3 == 3'd0) e.alu = ALU_SUB;
                else if (ins[30] && f3 == 3'd5)     e.alu = ALU_SRA;
                else                                e.alu = R_TBL[f3];
            end
            7'b0010011: begin
                e.it = INST_I; e.re1 = 1; e.wr = 3'b001; e.imm = s >>> 20;
                e.alu = (ins[30] && f3 == 3'd5) ? ALU_SRAI : I_TBL[f3];
            end
            7'b0000011: begin
                e.it = INST_L; e.re1 = 1; e.wr = 3'b011; e.mrd = 1; e.msize = f3;
                e.imm = s >>> 20; e.alu = ALU_ADD;
            end
            7'b0100011: begin
                e.it = INST_S; e.re1 = 1; e.re2 = 1; e.mwr = 1; e.msize = f3;
                e.imm = ((s >>> 25) << 5) | int'(ins[11:7]); e.alu = ALU_ADD;
            end
            7'b1100011: begin
                e.it = INST_B; e.re1 = 1; e.re2 = 1;
                e.imm = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11)
                      + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
                e.alu = B_ALU[f3]; e.pj = B_JMP[f3];
                e.ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b1101111: begin
                e.it = INST_J; e.wr = 3'b101; e.pj = 3'd1;
                e.imm = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12)
                      + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
            end
            7'b1100111: begin
                e.it = INST_JR; e.re1 = 1; e.wr = 3'b101; e.pj = 3'd4;
                e.imm = s >>> 20; e.alu = ALU_ADD;
            end
            7'b0110111: begin
                e.it = INST_U; e.wr = 3'b111; e.imm = ins & 32'hFFFF_F000;
            end
            7'b0010111: begin
                e.it = INST_UA; e.wr = 3'b001; e.imm = ins & 32'hFFFF_F000; e.alu = ALU_ADDPC;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e = '0; e.pc = pc; e.ill = 1;
        end
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("in_ready", bus.in_ready, exp_q.size() < DEPTH);
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_t'(exp_q[0]);
                check("out_pc", bus.out_pc, e.pc);
                check("rd", bus.rd, e.rd);
                check("rs1", bus.rs1, e.rs1);
                check("rs2", bus.rs2, e.rs2);
                check("imm", bus.imm, e.imm);
                check("inst_type", bus.inst_type, e.it);
                check("rd_en1", bus.rd_en1, e.re1);
                check("rd_en2", bus.rd_en2, e.re2);
                check("wr_en", bus.wr_en, e.wr);
                check("mem_rd", bus.mem_rd, e.mrd);
                check("mem_wr", bus.mem_wr, e.mwr);
                check("mem_size", bus.mem_size, e.msize);
                check("ALU_func", bus.ALU_func, e.alu);
                check("pc_jmp", bus.pc_jmp, e.pj);
                check("illegal", bus.illegal, e.ill);
            end else begin
                check("empty_pc_imm", {bus.out_pc, bus.imm}, 64'd0);
                check("empty_ctrl", {bus.rd, bus.rs1, bus.rs2, bus.inst_type, bus.rd_en1,
                                     bus.rd_en2, bus.wr_en, bus.mem_rd, bus.mem_wr,
                                     bus.mem_size, bus.ALU_func, bus.pc_jmp, bus.illegal}, 64'd0);
            end
            if (bus.flush) exp_q.delete();
            else begin
                if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (bus.in_valid && bus.in_ready) exp_q.push_back(W'(model(bus.in_pc, bus.instruction)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        int n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.instruction = ins;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("drain_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        w = $urandom();
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        if (w[6:0] == 7'b0110011 && $urandom_range(0, 2) == 0) w[31:25] = 7'b0000001;
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] pc;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.instruction = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_imm", bus.imm, 32'd0);

        // addi x1,x0,5
        send(32'h100, 32'h0050_0093);
        check("addi_valid", bus.out_valid, 1'b1);
        check("addi_rd", bus.rd, 5'd1);
        check("addi_rs1", bus.rs1, 5'd0);
        check("addi_imm", bus.imm, 32'd5);
        check("addi_alu", bus.ALU_func, ALU_ADDI);
        check("addi_wr_en", bus.wr_en, 3'b001);
        drain();

        // bne x1,x2,-4
        send(32'h104, 32'hFE20_9EE3);
        check("bne_imm", bus.imm, 32'hFFFF_FFFC);
        check("bne_pc_jmp", bus.pc_jmp, 3'd3);
        check("bne_alu", bus.ALU_func, ALU_EQL);
        check("bne_rd_en", {bus.rd_en1, bus.rd_en2}, 2'b11);
        check("bne_wr_en", bus.wr_en, 3'b000);
        drain();

        // lui x5,0x12345 and an unknown opcode
        send(32'h108, 32'h1234_52B7);
        check("lui_imm", bus.imm, 32'h1234_5000);
        check("lui_rd", bus.rd, 5'd5);
        check("lui_wr_en", bus.wr_en, 3'b111);
        drain();
        send(32'h10C, 32'h0000_007F);
        check("bad_illegal", bus.illegal, 1'b1);
        check("bad_wr_en", bus.wr_en, 3'b000);
        drain();

        // mul x3,x1,x2
        send(32'h110, 32'h0220_81B3);
        check("mul_illegal", bus.illegal, !M_EN);
        if (M_EN) begin
            check("mul_alu", bus.ALU_func, ALU_MUL);
            check("mul_wr_en", bus.wr_en, 3'b001);
        end else begin
            check("mul_wr_en", bus.wr_en, 3'b000);
            check("mul_rd_en", {bus.rd_en1, bus.rd_en2}, 2'b00);
        end
        drain();

        // backpressure: three words into a two-entry queue
        send(32'h2000, 32'h0010_0093);
        send(32'h2004, 32'h0020_0113);
        check("full_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1; bus.in_pc = 32'h2008; bus.instruction = 32'h0030_0193;
        bus.out_ready = 1'b1;
        check("full_pop_in_ready", bus.in_ready, 1'b0);
        check("order_pc0", bus.out_pc, 32'h2000);
        step();
        check("order_pc1", bus.out_pc, 32'h2004);
        check("reopen_in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("order_pc2", bus.out_pc, 32'h2008);
        step();
        check("drained_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // flush of a full queue while a word is offered
        send(32'h3000, 32'h0010_0093);
        send(32'h3004, 32'h0020_0113);
        bus.in_valid = 1'b1; bus.in_pc = 32'h3008; bus.instruction = 32'h0030_0193;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        step();
        step();
        check("flushed_never", bus.out_valid, 1'b0);

        // randomized traffic
        pc = 32'h8000;
        for (int c = 0; c < 600; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_pc       = pc;
            bus.instruction = rand_instr();
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 40) == 0);
            pc = pc + 32'd4;
            step();
        end
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        drain();

        // asynchronous reset while a transfer is pending
        bus.in_valid = 1'b1; bus.in_pc = 32'h4000; bus.instruction = 32'h0050_0093;
        step();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_imm", bus.imm, 32'd0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        check("post_rst_valid", bus.out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
